// File: rtl/puf_pkg.sv
// Shared types for the PUF majority voter: FSM encoding, default widths and tally sizing.
package puf_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StAccum,
        StVote,
        StHold
    } state_e;

    localparam int unsigned RespWDefault = 256;
    localparam int unsigned ChalWDefault = 8;

    // Tally must hold 0..num_eval inclusive.
    function automatic int unsigned tally_w(input int unsigned num_eval);
        return $clog2(num_eval + 1);
    endfunction

endpackage

// File: rtl/puf_bit_tally.sv
// Per-bit ones counter for the PUF voter; exposes the majority vote and the non-unanimous flag.
module puf_bit_tally
    import puf_pkg::*;
#(
    parameter int unsigned NUM_EVAL = 5,
    parameter int unsigned TALLY_W  = tally_w(NUM_EVAL)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic vote,
    output logic unstable
);

    logic [TALLY_W-1:0] tally;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tally <= '0;
        end else if (clr) begin
            tally <= '0;
        end else if (inc) begin
            tally <= tally + 1'b1;
        end
    end

    assign vote     = (tally > TALLY_W'(NUM_EVAL / 2));
    assign unstable = (tally != '0) && (tally != TALLY_W'(NUM_EVAL));

endmodule

// File: rtl/puf_response_voter.sv
// Majority-vote stabiliser for the RO-PUF: re-runs the PUF NUM_EVAL times and votes per bit.
// Optional per-evaluation watchdog and tmo_err port enabled by defining PUF_VOTE_TIMEOUT_EN.
module puf_response_voter
    import puf_pkg::*;
#(
    parameter int unsigned RESP_W   = RespWDefault,
    parameter int unsigned CHAL_W   = ChalWDefault,
    parameter int unsigned NUM_EVAL = 5,
    parameter int unsigned TMO_CYC  = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [CHAL_W-1:0] challenge_in,
    output logic              busy,
    output logic              puf_start,
    output logic [CHAL_W-1:0] puf_challenge,
    input  logic [RESP_W-1:0] puf_response,
    input  logic              puf_done,
    output logic [RESP_W-1:0] key_out,
    output logic [RESP_W-1:0] unstable_mask,
    output logic [8:0]        unstable_cnt,
    output logic              key_valid,
    input  logic              key_ready
`ifdef PUF_VOTE_TIMEOUT_EN
    ,
    output logic              tmo_err
`endif
);

    localparam int unsigned TallyW = tally_w(NUM_EVAL);

    if ((NUM_EVAL % 2 == 0) || (NUM_EVAL < 3) || (NUM_EVAL > 15) || (RESP_W > 256) ||
        (TMO_CYC == 0)) begin : g_param_check
        $error("puf_response_voter: unsupported parameter combination");
    end

    state_e              state;
    logic [TallyW-1:0]   eval_cnt;
    logic                done_q;
    logic [RESP_W-1:0]   resp_q;
    logic                done_edge;
    logic                tally_clr;
    logic                tally_inc;
    logic [RESP_W-1:0]   vote;
    logic [RESP_W-1:0]   unstable;
    logic [8:0]          pop;

    assign done_edge = puf_done & ~done_q;
    assign tally_clr = (state == StIdle) & req;
    assign tally_inc = (state == StAccum);

    for (genvar i = 0; i < RESP_W; i++) begin : g_tally
        puf_bit_tally #(
            .NUM_EVAL (NUM_EVAL),
            .TALLY_W  (TallyW)
        ) u_tally (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (tally_clr),
            .inc      (tally_inc & resp_q[i]),
            .vote     (vote[i]),
            .unstable (unstable[i])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < RESP_W; i++) begin
            pop = pop + 9'(unstable[i]);
        end
    end

`ifdef PUF_VOTE_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
    logic [TmoW-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            eval_cnt      <= '0;
            done_q        <= 1'b0;
            resp_q        <= '0;
            busy          <= 1'b0;
            puf_start     <= 1'b0;
            puf_challenge <= '0;
            key_out       <= '0;
            unstable_mask <= '0;
            unstable_cnt  <= '0;
            key_valid     <= 1'b0;
`ifdef PUF_VOTE_TIMEOUT_EN
            tmo_cnt       <= '0;
            tmo_err       <= 1'b0;
`endif
        end else begin
            // Tracked in every state so a done left high from a previous run is never an edge.
            done_q <= puf_done;
            case (state)
                StIdle: begin
                    if (req) begin
                        state         <= StLaunch;
                        puf_challenge <= challenge_in;
                        eval_cnt      <= '0;
                        busy          <= 1'b1;
                        puf_start     <= 1'b1;
                    end
                end
                StLaunch: begin
                    puf_start <= 1'b0;
                    state     <= StWait;
`ifdef PUF_VOTE_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                StWait: begin
                    if (done_edge) begin
                        resp_q <= puf_response;
                        state  <= StAccum;
                    end
`ifdef PUF_VOTE_TIMEOUT_EN
                    else if (tmo_cnt == TmoW'(TMO_CYC - 1)) begin
                        state         <= StHold;
                        key_valid     <= 1'b1;
                        tmo_err       <= 1'b1;
                        key_out       <= '0;
                        unstable_mask <= '1;
                        unstable_cnt  <= 9'(RESP_W);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                StAccum: begin
                    eval_cnt <= eval_cnt + 1'b1;
                    if (eval_cnt == TallyW'(NUM_EVAL - 1)) begin
                        state <= StVote;
                    end else begin
                        state     <= StLaunch;
                        puf_start <= 1'b1;
                    end
                end
                StVote: begin
                    key_out       <= vote;
                    unstable_mask <= unstable;
                    unstable_cnt  <= pop;
                    key_valid     <= 1'b1;
                    state         <= StHold;
                end
                StHold: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
`ifdef PUF_VOTE_TIMEOUT_EN
                        tmo_err   <= 1'b0;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_voter.sv
// Scoreboard bench for puf_response_voter with a behavioural PUF; define PUF_VOTE_TIMEOUT_EN
// to also exercise the watchdog build.
module tb_puf_response_voter;

    localparam int unsigned RESP_W   = 256;
    localparam int unsigned CHAL_W   = 8;
    localparam int unsigned NUM_EVAL = 5;
    localparam int unsigned PUF_LAT  = 3;

    logic              clk;
    logic              rst_n;
    logic              req;
    logic [CHAL_W-1:0] challenge_in;
    logic              busy;
    logic              puf_start;
    logic [CHAL_W-1:0] puf_challenge;
    logic [RESP_W-1:0] puf_response;
    logic              puf_done;
    logic [RESP_W-1:0] key_out;
    logic [RESP_W-1:0] unstable_mask;
    logic [8:0]        unstable_cnt;
    logic              key_valid;
    logic              key_ready;
`ifdef PUF_VOTE_TIMEOUT_EN
    logic              tmo_err;
`endif

    puf_response_voter #(
        .RESP_W   (RESP_W),
        .CHAL_W   (CHAL_W),
        .NUM_EVAL (NUM_EVAL),
        .TMO_CYC  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .challenge_in  (challenge_in),
        .busy          (busy),
        .puf_start     (puf_start),
        .puf_challenge (puf_challenge),
        .puf_response  (puf_response),
        .puf_done      (puf_done),
        .key_out       (key_out),
        .unstable_mask (unstable_mask),
        .unstable_cnt  (unstable_cnt),
        .key_valid     (key_valid),
        .key_ready     (key_ready)
`ifdef PUF_VOTE_TIMEOUT_EN
        ,
        .tmo_err       (tmo_err)
`endif
    );

    typedef struct {
        logic [RESP_W-1:0] key;
        logic [RESP_W-1:0] mask;
        logic [8:0]        cnt;
        logic              tmo;
    } exp_t;

    exp_t              sb[$];
    int                tests = 0;
    int                fails = 0;
    int                n_results = 0;
    int                start_cnt = 0;
    int                idx = 0;
    logic              puf_hang = 1'b0;
    logic [RESP_W-1:0] resp_tbl[NUM_EVAL];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [RESP_W-1:0] act,
                       input logic [RESP_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired waiting on DUT", name);
    endtask

    // Behavioural PUF: fresh 0->1 done edge PUF_LAT cycles after each start pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (puf_start && rst_n) begin
                start_cnt++;
                puf_done = 1'b0;
                if (!puf_hang) begin
                    repeat (PUF_LAT) @(posedge clk);
                    #1;
                    puf_response = resp_tbl[idx % NUM_EVAL];
                    idx++;
                    puf_done = 1'b1;
                end
            end
        end
    end

    // Monitor: pop and compare on every rising key_valid.
    initial begin
        logic valid_prev;
        exp_t e;
        valid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                valid_prev = 1'b0;
            end else begin
                if (key_valid && !valid_prev) begin
                    n_results++;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_unexpected: got result %h with no expectation", key_out);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_key", key_out, e.key);
                        chk("sb_mask", unstable_mask, e.mask);
                        chk("sb_cnt", RESP_W'(unstable_cnt), RESP_W'(e.cnt));
`ifdef PUF_VOTE_TIMEOUT_EN
                        chk("sb_tmo", RESP_W'(tmo_err), RESP_W'(e.tmo));
`endif
                    end
                end
                valid_prev = key_valid;
            end
        end
    end

    task automatic load5(input logic [RESP_W-1:0] r0, input logic [RESP_W-1:0] r1,
                         input logic [RESP_W-1:0] r2, input logic [RESP_W-1:0] r3,
                         input logic [RESP_W-1:0] r4);
        resp_tbl[0] = r0;
        resp_tbl[1] = r1;
        resp_tbl[2] = r2;
        resp_tbl[3] = r3;
        resp_tbl[4] = r4;
        idx = 0;
        start_cnt = 0;
    endtask

    task automatic push_exp(input logic [RESP_W-1:0] k, input logic [RESP_W-1:0] m,
                            input logic [8:0] c, input logic t);
        exp_t e;
        e.key = k;
        e.mask = m;
        e.cnt = c;
        e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic send_req(input logic [CHAL_W-1:0] ch);
        @(negedge clk);
        req = 1'b1;
        challenge_in = ch;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) fail_now(name);
    endtask

    task automatic wait_valid(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (key_valid) done = 1'b1;
        end
        if (!done) fail_now(name);
    endtask

    task automatic wait_starts(input int n, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #2;
            if (start_cnt >= n) done = 1'b1;
        end
        if (!done) fail_now(name);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, RESP_W'(busy), '0);
        chk({tag, "_start"}, RESP_W'(puf_start), '0);
        chk({tag, "_chal"}, RESP_W'(puf_challenge), '0);
        chk({tag, "_key"}, key_out, '0);
        chk({tag, "_mask"}, unstable_mask, '0);
        chk({tag, "_cnt"}, RESP_W'(unstable_cnt), '0);
        chk({tag, "_valid"}, RESP_W'(key_valid), '0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [RESP_W-1:0] pat, k, m, r3;
        int n;
        rst_n = 1'b0;
        req = 1'b0;
        challenge_in = '0;
        key_ready = 1'b1;
        puf_done = 1'b0;
        puf_response = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Unanimous 0xA5 pattern
        pat = {32{8'hA5}};
        load5(pat, pat, pat, pat, pat);
        push_exp(pat, '0, 9'd0, 1'b0);
        send_req(8'h01);
        wait_idle("t1_idle");
        chk("t1_starts", RESP_W'(start_cnt), RESP_W'(5));
        chk("t1_chal", RESP_W'(puf_challenge), RESP_W'(8'h01));

        // bit0 set 3/5, bit1 set 2/5
        load5(RESP_W'(3), RESP_W'(3), RESP_W'(1), RESP_W'(0), RESP_W'(0));
        push_exp(RESP_W'(1), RESP_W'(3), 9'd2, 1'b0);
        send_req(8'h02);
        wait_idle("t2_idle");

        // Top byte 4/5 ones (vote 1, unstable), low nibble unanimous
        k = '0;
        k[255:248] = 8'hFF;
        k[7:0] = 8'h0F;
        m = '0;
        m[255:248] = 8'hFF;
        load5(k, k, k, k, RESP_W'(8'h0F));
        push_exp(k, m, 9'd8, 1'b0);
        send_req(8'h03);
        wait_idle("t2b_idle");

        // Consumer stalls 20 cycles
        pat = {16{16'h1234}};
        key_ready = 1'b0;
        load5(pat, pat, pat, pat, pat);
        push_exp(pat, '0, 9'd0, 1'b0);
        send_req(8'h22);
        wait_valid("t3_valid");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_hold_key", key_out, pat);
            chk("t3_hold_valid", RESP_W'(key_valid), RESP_W'(1));
            chk("t3_hold_busy", RESP_W'(busy), RESP_W'(1));
        end
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_rel_valid", RESP_W'(key_valid), '0);
        chk("t3_rel_busy", RESP_W'(busy), '0);
        chk("t3_rel_key_kept", key_out, pat);
        @(negedge clk);

        // req during WAIT and HOLD ignored; bit 100 cleared in one evaluation only
        pat = {32{8'h5A}};
        r3 = pat;
        r3[100] = 1'b0;
        m = '0;
        m[100] = 1'b1;
        key_ready = 1'b0;
        load5(pat, pat, pat, r3, pat);
        push_exp(pat, m, 9'd1, 1'b0);
        send_req(8'h3C);
        wait_starts(2, "t4_start2");
        @(posedge clk);
        @(negedge clk);
        req = 1'b1;
        challenge_in = 8'hC3;
        @(negedge clk);
        req = 1'b0;
        chk("t4_chal_wait", RESP_W'(puf_challenge), RESP_W'(8'h3C));
        wait_valid("t4_valid");
        req = 1'b1;
        challenge_in = 8'h77;
        repeat (3) @(negedge clk);
        chk("t4_hold_valid", RESP_W'(key_valid), RESP_W'(1));
        chk("t4_chal_hold", RESP_W'(puf_challenge), RESP_W'(8'h3C));
        key_ready = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_busy", RESP_W'(busy), '0);
        chk("t4_starts", RESP_W'(start_cnt), RESP_W'(5));
        chk("t4_chal_end", RESP_W'(puf_challenge), RESP_W'(8'h3C));

        // Reset during the third WAIT, then a clean rerun
        pat = {8{32'hDEADBEEF}};
        load5(pat, pat, pat, pat, pat);
        send_req(8'h11);
        wait_starts(3, "t5_start3");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        sb.delete();
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        puf_done = 1'b0;
        load5(pat, pat, pat, pat, pat);
        @(negedge clk);
        chk("t5_idle_busy", RESP_W'(busy), '0);
        push_exp(pat, '0, 9'd0, 1'b0);
        send_req(8'h12);
        wait_idle("t5_idle");
        chk("t5_starts", RESP_W'(start_cnt), RESP_W'(5));
        chk("t5_chal", RESP_W'(puf_challenge), RESP_W'(8'h12));

`ifdef PUF_VOTE_TIMEOUT_EN
        // done never rises: watchdog fires after 16 WAIT cycles
        puf_hang = 1'b1;
        key_ready = 1'b0;
        load5('0, '0, '0, '0, '0);
        push_exp('0, '1, 9'd256, 1'b1);
        send_req(8'h66);
        n = 0;
        while (!key_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_latency", RESP_W'(n), RESP_W'(17));
        @(negedge clk);
        chk("t6_tmo", RESP_W'(tmo_err), RESP_W'(1));
        chk("t6_busy", RESP_W'(busy), RESP_W'(1));
        chk("t6_starts", RESP_W'(start_cnt), RESP_W'(1));
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_tmo_clr", RESP_W'(tmo_err), '0);
        chk("t6_valid_clr", RESP_W'(key_valid), '0);
        puf_hang = 1'b0;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", RESP_W'(sb.size()), '0);
`ifdef PUF_VOTE_TIMEOUT_EN
        chk("results_seen", RESP_W'(n_results), RESP_W'(7));
`else
        chk("results_seen", RESP_W'(n_results), RESP_W'(6));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
